regfile_scoreboard: RTL

Parametrised, fully synchronous register file with two registered read ports, one write port with write-to-read bypass, and a per-register busy scoreboard. It is the next-generation register file for the lab processor datapath. It sits between the instruction decode stage, which reads operands and reserves destinations, and the ALU writeback, which writes results and clears reservations. The scoreboard lets the controller detect read-after-write hazards without extra logic.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 47 ++++
 rtl/regfile_scoreboard.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
// Imported by the RTL and by the testbench.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 8;
  localparam int REGFILE_DEPTH = 8;
  localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

  // Register index sized for the default depth.
  typedef logic [REGFILE_AW-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
// Selects stored data or same-cycle write data (write-first bypass),
// picks the next-state busy bit of the addressed register, and holds
// both outputs while i_rd_en is low.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_mem,
  input  logic                         i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic [DEPTH-1:0]             i_busy_next,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_busy
);

  logic [WIDTH-1:0] w_data_next;
  logic             w_busy_sel;

  // Write-first bypass: a write to the address being read wins over storage.
  assign w_data_next = (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data
                                                             : i_mem[i_rd_addr];

  // Busy status reflects this cycle's reservations and clears.
  assign w_busy_sel = i_busy_next[i_rd_addr];

  // Output registers, updated only when the read strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_busy <= 1'b0;
    end else if (i_rd_en) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values, independent of statement order.
      o_data <= w_data_next;
      o_busy <= w_busy_sel;
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port with
// write-to-read bypass, and a per-register busy scoreboard for RAW hazard
// detection between decode (reserve) and writeback (write + clear).
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to
// zero (writes and reservations to address 0 are ignored).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REGFILE_WIDTH,
  parameter  int DEPTH = REGFILE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    INaddr,
  input  logic             WRITE_EN,
  input  logic             RSV_EN,
  input  logic [AW-1:0]    RSV_addr,
  input  logic [AW-1:0]    OUT1addr,
  input  logic [AW-1:0]    OUT2addr,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic             OUT1_BUSY,
  output logic             OUT2_BUSY,
  output logic [DEPTH-1:0] BUSY_VEC,
  output logic             RSV_ERR
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_busy;
  logic                        r_rsv_err;
  logic [DEPTH-1:0]            w_busy_next;
  logic                        w_we;
  logic                        w_rsv;
  logic                        w_rsv_err_next;

`ifdef REGFILE_ZERO_REG_EN
  // Register 0 is constant zero: drop writes, bypass and reservations to it.
  assign w_we  = WRITE_EN && (INaddr != '0);
  assign w_rsv = RSV_EN && (RSV_addr != '0);
`else
  assign w_we  = WRITE_EN;
  assign w_rsv = RSV_EN;
`endif

  // Scoreboard next state: reserve sets, write clears, reserve wins a tie.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_busy_next unassigned
    // (which would infer a latch).
    w_busy_next = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rsv && (RSV_addr == AW'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (WRITE_EN && (INaddr == AW'(i))) begin
        w_busy_next[i] = 1'b0;
      end
    end
  end

  // A reservation of a register that is busy and not being freed this cycle.
  assign w_rsv_err_next = w_rsv && r_busy[RSV_addr]
                        && !(WRITE_EN && (INaddr == RSV_addr));

  // Storage array; cleared on reset so reads after reset return zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the array is reset explicitly because reads after reset must
      // return zero; a plain RAM without reset would not guarantee that.
      r_mem <= '0;
    end else if (w_we) begin
      r_mem[INaddr] <= IN;
    end
  end

  // Busy scoreboard and reservation-error pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_next;
      r_rsv_err <= w_rsv_err_next;
    end
  end

  assign BUSY_VEC = r_busy;
  assign RSV_ERR  = r_rsv_err;

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port1 (
    .clk         (CLK),
    .rst_n       (RESET),
    .i_rd_en     (RD_EN),
    .i_rd_addr   (OUT1addr),
    .i_mem       (r_mem),
    .i_wr_en     (w_we),
    .i_wr_addr   (INaddr),
    .i_wr_data   (IN),
    .i_busy_next (w_busy_next),
    .o_data      (OUT1),
    .o_busy      (OUT1_BUSY)
  );

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port2 (
    .clk         (CLK),
    .rst_n       (RESET),
    .i_rd_en     (RD_EN),
    .i_rd_addr   (OUT2addr),
    .i_mem       (r_mem),
    .i_wr_en     (w_we),
    .i_wr_addr   (INaddr),
    .i_wr_data   (IN),
    .i_busy_next (w_busy_next),
    .o_data      (OUT2),
    .o_busy      (OUT2_BUSY)
  );

endmodule : regfile_scoreboard
